// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide engine that owns the architectural HI/LO pair.
//   It runs one operation at a time: an accepted start is followed by XLEN
//   iteration cycles and one sign-fix cycle. HI/LO are written in the fix
//   cycle, and done pulses for the cycle after that.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_b    : synchronous reset, ACTIVE-HIGH despite the name
//   start    : begin an operation (ignored while busy)
//   op       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//   rs_data  : multiplicand / dividend
//   rt_data  : multiplier / divisor
//   hi_we    : MTHI write enable (honoured only while idle)
//   lo_we    : MTLO write enable (honoured only while idle)
//   wdata    : MTHI/MTLO write data
//   busy     : operation in flight
//   done     : one-cycle pulse after HI/LO take a new result
//   hi, lo   : architectural HI/LO registers
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW  = $clog2(XLEN);
  localparam int XL2 = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's complement negation at operand width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] x);
    return ~x + XLEN'(1);
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [XLEN-1:0] mag_x(input logic [XLEN-1:0] x,
                                            input logic            is_signed);
    logic [XLEN-1:0] r;
    if (is_signed && x[XLEN-1]) begin
      r = neg_x(x);
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic            busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            is_div_r, neg_res_r, neg_rem_r;
  logic [XLEN-1:0] opa_r;        // multiplicand magnitude
  logic [XLEN-1:0] opb_r;        // divisor magnitude
  logic [XL2-1:0]  prod_r;       // {partial sum, remaining multiplier bits}
  logic [XLEN-1:0] quo_r;        // dividend bits shifting out, quotient bits in
  logic [XLEN-1:0] rem_r;

  logic            rs_neg_s, rt_neg_s;
  logic [XLEN-1:0] rs_mag_s, rt_mag_s;
  logic [XLEN:0]   add_s;        // one extra bit for the add carry
  logic [XLEN:0]   shf_s;        // trial remainder, XLEN+1 wide
  logic [XLEN:0]   dif_s;        // trial subtraction; MSB is the borrow
  logic            qbit_s;
  logic [XL2-1:0]  prod_fix_s;
  logic [XLEN-1:0] res_hi_s, res_lo_s;

  assign busy = busy_r;
  assign done = done_r;

  // State register plus the registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CW'(XLEN - 1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: values that busy/done take after the coming edge.
  always_comb begin
    busy_nxt_s = (state_nxt_s != IDLE);
    done_nxt_s = (state_r == FIX);
  end

  // Operand magnitudes and sign flags captured at start.
  always_comb begin
    rs_neg_s = op[0] & rs_data[XLEN-1];
    rt_neg_s = op[0] & rt_data[XLEN-1];
    rs_mag_s = mag_x(rs_data, op[0]);
    rt_mag_s = mag_x(rt_data, op[0]);
  end

  // One iteration of the multiplier and the divider.
  always_comb begin
    if (prod_r[0]) begin
      add_s = {1'b0, prod_r[XL2-1:XLEN]} + {1'b0, opa_r};
    end else begin
      add_s = {1'b0, prod_r[XL2-1:XLEN]};
    end
    shf_s  = {rem_r, quo_r[XLEN-1]};
    dif_s  = shf_s - {1'b0, opb_r};
    qbit_s = ~dif_s[XLEN];
  end

  // Iteration datapath and iteration counter.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt_r     <= {CW{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      opa_r     <= {XLEN{1'b0}};
      opb_r     <= {XLEN{1'b0}};
      prod_r    <= {XL2{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r     <= {CW{1'b0}};
            is_div_r  <= op[1];
            // A zero divisor is not treated as a sign flip, so a divide by
            // zero leaves the all-ones quotient intact for DIV as well.
            neg_res_r <= (rs_neg_s ^ rt_neg_s) & (~op[1] | (rt_data != {XLEN{1'b0}}));
            neg_rem_r <= op[1] & rs_neg_s;
            opa_r     <= rs_mag_s;
            opb_r     <= rt_mag_s;
            prod_r    <= {{XLEN{1'b0}}, rt_mag_s};
            quo_r     <= rs_mag_s;
            rem_r     <= {XLEN{1'b0}};
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CW'(1);
          if (is_div_r) begin
            quo_r <= {quo_r[XLEN-2:0], qbit_s};
            if (qbit_s) begin
              rem_r <= dif_s[XLEN-1:0];
            end else begin
              rem_r <= shf_s[XLEN-1:0];
            end
          end else begin
            prod_r <= {add_s, prod_r[XLEN-1:1]};
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Sign correction of the final result.
  always_comb begin
    if (neg_res_r) begin
      prod_fix_s = ~prod_r + XL2'(1);
    end else begin
      prod_fix_s = prod_r;
    end
    if (is_div_r) begin
      res_lo_s = neg_res_r ? neg_x(quo_r) : quo_r;
      res_hi_s = neg_rem_r ? neg_x(rem_r) : rem_r;
    end else begin
      res_lo_s = prod_fix_s[XLEN-1:0];
      res_hi_s = prod_fix_s[XL2-1:XLEN];
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only while idle.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      hi <= {XLEN{1'b0}};
      lo <= {XLEN{1'b0}};
    end else if (state_r == FIX) begin
      hi <= res_hi_s;
      lo <= res_lo_s;
    end else if (state_r == IDLE) begin
      if (hi_we) begin
        hi <= wdata;
      end
      if (lo_we) begin
        lo <= wdata;
      end
    end
  end

endmodule
